// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the DataMemory arbiter: FSM encoding, port ids, default widths.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DATA_W = 8;

endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating starvation counter: counts port 1's lost arbitrations, flags MAX_WAIT.
module dmem_wait_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [3:0] MAX_C = 4'(MAX_WAIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != MAX_C))
      cnt_d = cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port req/ack arbiter and one-access sequencer in front of DataMemory.
// Optional grant statistics counters enabled by macro DMEM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a request; arbitrate and latch the winner's fields
// BUSY  | memory strobes driven for one cycle; read data captured at the closing edge
// DONE  | one-cycle ack to the latched port, strobes low
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] endereco,
  output logic [DATA_W-1:0] valor_escrita,
  input  logic [DATA_W-1:0] valor_saida
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  state_e            state_q;
  logic              gnt_id_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ack0_q, ack1_q, busy_q, mem_write_q, mem_read_q;

  logic              idle, any_req, at_max;
  logic              pick1_d, we_d, wait_inc, wait_clr;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;

  assign idle    = (state_q == ST_IDLE);
  assign any_req = req0 | req1;
  // Port 0 has priority unless port 1 has lost MAX_WAIT arbitrations in a row.
  assign pick1_d = req1 & (~req0 | at_max);
  assign we_d    = pick1_d ? we1    : we0;
  assign addr_d  = pick1_d ? addr1  : addr0;
  assign wdata_d = pick1_d ? wdata1 : wdata0;

  assign wait_inc = idle & req1 & ~pick1_d;
  assign wait_clr = idle & (~req1 | pick1_d);

  dmem_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk    (clk),
    .reset  (reset),
    .inc    (wait_inc),
    .clr    (wait_clr),
    .at_max (at_max)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      gnt_id_q    <= PORT_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_id_q    <= pick1_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_write_q <= we_d;
            mem_read_q  <= ~we_d;
            busy_q      <= 1'b1;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!we_q)
            rdata_q <= valor_saida;
          ack0_q  <= (gnt_id_q == PORT_CPU);
          ack1_q  <= (gnt_id_q == PORT_AUX);
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack0          = ack0_q;
  assign ack1          = ack1_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign mem_write     = mem_write_q;
  assign mem_read      = mem_read_q;
  assign endereco      = addr_q;
  assign valor_escrita = wdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
    end else begin
      if (ack0_q) grant_cnt0_q <= grant_cnt0_q + 16'd1;
      if (ack1_q) grant_cnt1_q <= grant_cnt1_q + 16'd1;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory model.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, we0, req1, we1;
  logic [5:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1, busy, mem_write, mem_read;
  logic [7:0] rdata, valor_escrita, valor_saida;
  logic [5:0] endereco;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .req0          (req0),
    .we0           (we0),
    .addr0         (addr0),
    .wdata0        (wdata0),
    .ack0          (ack0),
    .req1          (req1),
    .we1           (we1),
    .addr1         (addr1),
    .wdata1        (wdata1),
    .ack1          (ack1),
    .rdata         (rdata),
    .busy          (busy),
    .mem_write     (mem_write),
    .mem_read      (mem_read),
    .endereco      (endereco),
    .valor_escrita (valor_escrita),
    .valor_saida   (valor_saida)
`ifdef DMEM_ARB_STATS_EN
    ,
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1)
`endif
  );

  logic [7:0] mem [64];
  always @(posedge clk) if (mem_write) mem[endereco] <= valor_escrita;
  assign valor_saida = mem[endereco];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-port access with fixed latency; request fields are scrambled after grant.
  task automatic access(input bit p, input bit w, input logic [5:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    logic [7:0] rd_before;
    rd_before = rdata;
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    tick();
    check("busy_in_busy", busy, 1);
    check("mem_write_busy", mem_write, w);
    check("mem_read_busy", mem_read, !w);
    check("endereco", endereco, a);
    check("valor_escrita", valor_escrita, d);
    check("no_early_ack", ack0 | ack1, 0);
    if (!p) begin addr0 = ~a; wdata0 = ~d; end
    else    begin addr1 = ~a; wdata1 = ~d; end
    tick();
    check("ack0_done", ack0, !p);
    check("ack1_done", ack1, p);
    check("busy_done", busy, 1);
    check("strobes_done", mem_write | mem_read, 0);
    check("rdata_done", rdata, w ? rd_before : exp_rd);
    if (!p) req0 = 1'b0; else req1 = 1'b0;
    tick();
    check("ack_cleared", ack0 | ack1, 0);
    check("busy_idle", busy, 0);
    check("rdata_held", rdata, w ? rd_before : exp_rd);
  endtask

  initial begin
    int  n0;
    bit  got1;
    bit  first_seen;
    reset = 1'b1;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    tick(); tick();
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_rdata", rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_strobes", mem_write | mem_read, 0);
    check("rst_endereco", endereco, 0);
    check("rst_valor", valor_escrita, 0);
    check("rst_state", dut.state_q, ST_IDLE);
    reset = 1'b0;
    tick();

    access(0, 1, 6'd10, 8'hA5, 8'h00);
    access(0, 0, 6'd10, 8'h00, 8'hA5);
    access(1, 1, 6'd20, 8'h3C, 8'h00);
    access(1, 0, 6'd20, 8'h00, 8'h3C);
    access(1, 1, 6'd30, 8'h7E, 8'h00);

    // Port 0 streams back-to-back reads while port 1 waits for address 30.
    req0 = 1; we0 = 0; addr0 = 6'd10;
    req1 = 1; we1 = 0; addr1 = 6'd30;
    n0 = 0; got1 = 0; first_seen = 0;
    for (int i = 0; i < 40 && !got1; i++) begin
      tick();
      if (ack0 || ack1) check("ack_exclusive", ack0 & ack1, 0);
      if (!first_seen && (ack0 || ack1)) begin
        first_seen = 1;
        check("first_grant_port0", ack0, 1);
      end
      if (ack0) begin
        n0++;
        check("port0_stream_rdata", rdata, 8'hA5);
      end
      if (ack1) begin
        got1 = 1;
        check("aux_rdata", rdata, 8'h7E);
        check("aux_losses", n0[15:0], 16'd4);
        check("wait_cnt_cleared", dut.u_wait.cnt_q, 0);
        req1 = 0;
        req0 = 0;
      end
    end
    check("aux_granted", got1, 1);
    tick();
    check("drain_idle", dut.state_q, ST_IDLE);

    // Reset during BUSY of a read discards the read.
    req0 = 1; we0 = 0; addr0 = 6'd15;
    tick();
    check("rd_busy", busy, 1);
    reset = 1;
    tick();
    check("rd_rst_ack0", ack0, 0);
    check("rd_rst_rdata", rdata, 0);
    check("rd_rst_busy", busy, 0);
    check("rd_rst_state", dut.state_q, ST_IDLE);
    reset = 0; req0 = 0;
    tick();
    check("rd_rst_no_ack", ack0, 0);

    // Reset during BUSY of a write still commits the data.
    req0 = 1; we0 = 1; addr0 = 6'd15; wdata0 = 8'h99;
    tick();
    check("wr_busy_strobe", mem_write, 1);
    reset = 1; req0 = 0;
    tick();
    check("wr_rst_ack0", ack0, 0);
    check("wr_rst_state", dut.state_q, ST_IDLE);
    reset = 0;
    tick();
    check("wr_rst_no_ack", ack0, 0);
    access(0, 0, 6'd15, 8'h00, 8'h99);

`ifdef DMEM_ARB_STATS_EN
    reset = 1;
    tick();
    reset = 0;
    check("stats_rst0", grant_cnt0, 0);
    check("stats_rst1", grant_cnt1, 0);
    tick();
    access(0, 1, 6'd1, 8'h11, 8'h00);
    access(1, 1, 6'd2, 8'h22, 8'h00);
    access(0, 0, 6'd1, 8'h00, 8'h11);
    access(1, 0, 6'd2, 8'h00, 8'h22);
    access(0, 0, 6'd2, 8'h00, 8'h22);
    check("stats_cnt0", grant_cnt0, 16'd3);
    check("stats_cnt1", grant_cnt1, 16'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the single-cycle processor's DataMemory (6-bit address, 8-bit data). It shares the memory between port 0 (CPU load/store) and port 1 (loader/debug) using a req/ack handshake. It drives the memory's mem_write, mem_read, endereco and valor_escrita, and returns registered read data. Port 0 has fixed priority; an anti-starvation counter promotes port 1 after MAX_WAIT lost cycles.

Parameters:
ADDR_W, 6, address width; matches DataMemory endereco.
DATA_W, 8, data width; matches valor_escrita and valor_saida.
MAX_WAIT, 4, lost-arbitration cycles after which port 1 wins; range 1..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req0  input  1  port 0 request; held high with we0/addr0/wdata0 stable until ack0.
we0  input  1  port 0: 1 = write, 0 = read.
addr0  input  ADDR_W  port 0 address.
wdata0  input  DATA_W  port 0 write data.
ack0  output  1  one-cycle completion pulse for port 0.
req1, we1, addr1, wdata1, ack1  same as port 0, for port 1.
rdata  output  DATA_W  read data; valid in the ack cycle of a read.
busy  output  1  high in BUSY and DONE.
mem_write  output  1  to DataMemory.
mem_read  output  1  to DataMemory.
endereco  output  ADDR_W  to DataMemory.
valor_escrita  output  DATA_W  to DataMemory.
valor_saida  input  DATA_W  from DataMemory; combinational read data.

Behaviour:
- Reset values: state=IDLE, ack0=ack1=0, rdata=0, busy=0, mem_write=mem_read=0, endereco=0, valor_escrita=0, wait counter=0, latched grant id=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - Otherwise pick a winner. Port 1 wins if req1 is high and (req0 is low or wait_cnt==MAX_WAIT); else port 0 wins.
  - Latch the winner's id, we, addr and wdata into registers, then go to BUSY.
- BUSY (exactly one cycle):
  - Drive endereco and valor_escrita from the latched fields.
  - mem_write = latched we; mem_read = !latched we.
  - At the closing edge: for a read, capture valor_saida into rdata; a write commits in DataMemory. Go to DONE.
- DONE (one cycle):
  - ack of the latched port = 1; other ack = 0; mem_write=mem_read=0.
  - rdata holds the read value; it is unchanged after a write.
  - Go to IDLE.
- Latency and throughput: req sampled in IDLE at cycle t gives ack at t+2. Maximum throughput is one access per 3 cycles.
- Requester rule: deassert req in the cycle after ack, or present a new request. A req still high in IDLE is a new access.
- Outside BUSY, mem_write and mem_read are 0; endereco and valor_escrita hold their last values.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) in each IDLE cycle where req1=1 and port 0 wins.
  - Clears when port 1 is granted or when req1=0.
  - Holds in BUSY and DONE.
- Simultaneous req0 and req1 with wait_cnt<MAX_WAIT: port 0 is granted and port 1 keeps waiting.
- Request fields are sampled only at grant. Changes on the inputs during BUSY or DONE are ignored.
- Reset mid-operation: the FSM returns to IDLE and no ack is issued.
  - A write in BUSY at the reset edge still commits, because DataMemory samples mem_write=1 on that edge.
  - A read in BUSY at the reset edge is discarded; rdata=0.

Optional Feature:
Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each). Each increments on its port's ack, wraps at 0xFFFF to 0, and clears on reset.
- Undefined: these ports and counters do not exist, and arbitration behaviour is identical.

Decomposition:
- Shared package/header dmem_arb_pkg:
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Port id constants PORT_CPU=0 and PORT_AUX=1.
  - Default widths ADDR_W and DATA_W.
- One natural sub-module: dmem_wait_counter, the saturating starvation counter.
  - Inputs: inc, clr.
  - Output: at_max.
  - Parameter: MAX_WAIT.

Test Plan:
- Port 0 only: write 0xA5 to address 10, then read address 10 → ack0 at t+2 each time; the read gives rdata=0xA5; ack1 stays 0.
- Port 1 only: write 0x3C to address 20, then read → rdata=0x3C; mem_read is high only in the BUSY cycle.
- Both requesting simultaneously with MAX_WAIT=4: port 0 is granted first; port 1 is granted no later than after 4 lost IDLE arbitrations; ack0 and ack1 are never high together.
- Port 0 requests continuously (back-to-back requests) while port 1 requests a read of address 30, preloaded with 0x7E → port 1 is acked with rdata=0x7E within 5 grants; wait_cnt then clears to 0.
- Reset asserted during the BUSY cycle of a port 0 read at address 15 → next cycle IDLE, rdata=0, no ack0; a write in the same position commits its data (verified by a later read).
- With DMEM_ARB_STATS_EN defined: 3 port 0 accesses and 2 port 1 accesses → grant_cnt0=3, grant_cnt1=2; both are 0 after reset.
